// File: rtl/uart_block_rx.sv
// Oversampling 8N1 UART receiver that packs BLOCK_BYTES bytes into one block behind a valid/ready output.
// Optional MODE_TAG_EN: block_mode flags blocks whose first byte is 8'hFF.
`timescale 1ns/1ps
module uart_block_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUDRATE     = 115_200,
  parameter int OVERSAMPLE   = 16,
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic                     block_mode,
  output logic                     frame_err,
  output logic                     timeout,
  output logic                     overrun,
  output logic                     busy
);
  localparam int DIV      = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int DIV_W    = $clog2(DIV + 1);
  localparam int OS_W     = $clog2(OVERSAMPLE + 1);
  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_TICKS + 1);
  localparam int IDX_W    = $clog2(BLOCK_BYTES + 1);
  localparam int BW       = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [BW-1:0]    buf_q, buf_d, blk_next;
  logic [BW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             run, tick, complete, load;

  // The divider also runs while idle with a partial block so the timeout can count bit-times.
  assign run  = (state_q != S_IDLE) || (idx_q != '0);
  assign tick = run && (div_q == DIV_W'(DIV - 1));
  assign load = complete && (!valid_q || block_ready);

  always_comb begin
    state_d     = state_q;
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    div_d       = '0;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    to_d        = to_q;
    buf_d       = buf_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
    blk_next    = buf_q;
    blk_next[int'(idx_q)*8 +: 8] = shift_q;

    if (run) div_d = tick ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          state_d = S_START;
          div_d   = '0;
          os_d    = '0;
          to_d    = '0;
        end else if (tick && idx_q != '0) begin
          if (to_q == TO_W'(TO_TICKS - 1)) begin
            idx_d     = '0;
            to_d      = '0;
            timeout_d = 1'b1;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      S_START: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE/2 - 1)) begin
            state_d = rx_s2_q ? S_IDLE : S_DATA;
            os_d    = '0;
            bit_d   = '0;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            shift_d = {rx_s2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            state_d = S_IDLE;
            os_d    = '0;
            if (rx_s2_q) begin
              buf_d = blk_next;
              if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
                idx_d    = '0;
                complete = 1'b1;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              frame_err_d = 1'b1;
              idx_d       = '0;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
    endcase

    // A block finishing on the accepting clock replaces the old one without an overrun.
    if (load) begin
      data_d  = blk_next;
      valid_d = 1'b1;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (valid_q && block_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      div_q       <= '0;
      os_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      to_q        <= '0;
      buf_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      div_q       <= div_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      to_q        <= to_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef MODE_TAG_EN
  logic mode_q, mode_d;
  always_comb begin
    mode_d = mode_q;
    if (load) mode_d = (blk_next[7:0] == 8'hFF);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end
  assign block_mode = mode_q;
`else
  assign block_mode = 1'b0;
`endif

  assign block_data  = data_q;
  assign block_valid = valid_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_block_rx.sv
// Bench for uart_block_rx: a byte/block level model predicts blocks and event pulses, a negedge monitor checks the DUT.
`timescale 1ns/1ps
module tb_uart_block_rx;
  localparam int BB     = 16;
  localparam int BW     = 8 * BB;
  localparam int BIT_NS = 640;  // 1_562_500 baud at 50 MHz, 16x oversample: two clocks per tick

  logic          clk = 1'b0, reset = 1'b1, rx = 1'b1, block_ready = 1'b1;
  logic [BW-1:0] block_data;
  logic          block_valid, block_mode, frame_err, timeout, overrun, busy;

  uart_block_rx #(
    .CLK_FREQ(50_000_000), .BAUDRATE(1_562_500), .OVERSAMPLE(16),
    .BLOCK_BYTES(BB), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .block_data(block_data),
    .block_valid(block_valid), .block_ready(block_ready), .block_mode(block_mode),
    .frame_err(frame_err), .timeout(timeout), .overrun(overrun), .busy(busy)
  );

  always #10 clk = ~clk;

  int errs = 0, checks = 0;
  logic [BW-1:0] exp_q[$];
  logic          exp_mode_q[$];
  logic [7:0]    m_bytes[$];
  int            exp_fe = 0, exp_to = 0, exp_ov = 0;
  int            n_fe = 0, n_to = 0, n_ov = 0, n_acc = 0;
  bit            out_full = 1'b0;
  logic [BW-1:0] last_blk = '0, model_blk = '0;
  logic          last_mode = 1'b0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: bytes accumulate in a list; a full list becomes an expected block or an overrun.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [BW-1:0] blk;
    logic          mode;
    if (!good) begin
      exp_fe++;
      m_bytes.delete();
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == BB) begin
        blk = '0;
        for (int i = 0; i < BB; i++) blk[8*i +: 8] = m_bytes[i];
`ifdef MODE_TAG_EN
        mode = (m_bytes[0] == 8'hFF);
`else
        mode = 1'b0;
`endif
        m_bytes.delete();
        model_blk = blk;
        if (out_full) exp_ov++;
        else begin
          exp_q.push_back(blk);
          exp_mode_q.push_back(mode);
          if (!block_ready) out_full = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input int gap_bits);
    model_byte(b, good);
    rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 8; i++) begin rx = b[i]; #(BIT_NS); end
    if (good) begin
      rx = 1'b1; #(BIT_NS);
    end else begin
      rx = 1'b0; #(BIT_NS*3/4);
      rx = 1'b1; #(BIT_NS/4 + 2*BIT_NS);
    end
    #(gap_bits*BIT_NS);
  endtask

  task automatic send_rand(input int n, input int first);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (i == 0 && first >= 0) ? 8'(first) : 8'($urandom);
      send_byte(b, 1'b1, $urandom_range(0, 2));
    end
  endtask

  task automatic settle(input string nm);
    #(4*BIT_NS);
    chk({nm, "_blocks_pending"}, BW'(exp_q.size()), '0);
    chk({nm, "_fe_pending"}, BW'(exp_fe), '0);
    chk({nm, "_to_pending"}, BW'(exp_to), '0);
    chk({nm, "_ov_pending"}, BW'(exp_ov), '0);
  endtask

  // Monitor: every valid cycle must show the head expected block; every pulse must be expected.
  always @(negedge clk) begin
    if (!reset) begin
      if (block_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL spurious_valid: got block_valid=1 expected 0");
        end else begin
          chk("blk_data", block_data, exp_q[0]);
          chk("blk_mode", BW'(block_mode), BW'(exp_mode_q[0]));
          if (block_ready) begin
            last_blk  = block_data;
            last_mode = block_mode;
            void'(exp_q.pop_front());
            void'(exp_mode_q.pop_front());
            out_full = 1'b0;
            n_acc++;
          end
        end
      end
      if (frame_err) begin
        n_fe++; checks++;
        if (exp_fe == 0) begin errs++; $display("FAIL frame_err_pulse: got 1 expected 0"); end
        else exp_fe--;
      end
      if (timeout) begin
        n_to++; checks++;
        if (exp_to == 0) begin errs++; $display("FAIL timeout_pulse: got 1 expected 0"); end
        else exp_to--;
      end
      if (overrun) begin
        n_ov++; checks++;
        if (exp_ov == 0) begin errs++; $display("FAIL overrun_pulse: got 1 expected 0"); end
        else exp_ov--;
      end
    end
  end

  logic [7:0] t1 [BB] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h7A, 8'h9B, 8'h9B, 8'h9B,
                          8'h86, 8'hD2, 8'hD2, 8'h7A, 8'h7A, 8'h7B, 8'h7A, 8'h86};
  logic [BW-1:0] blk_a;

  initial begin
    #95;
    chk("rst_valid", BW'(block_valid), '0);
    chk("rst_data", block_data, '0);
    chk("rst_mode", BW'(block_mode), '0);
    chk("rst_pulses", BW'({frame_err, timeout, overrun}), '0);
    chk("rst_busy", BW'(busy), '0);
    @(posedge clk); #1 reset = 1'b0;
    #(2*BIT_NS);

    // 1: fixed block
    for (int i = 0; i < BB; i++) send_byte(t1[i], 1'b1, 1);
    settle("t1");
    chk("t1_byte0", BW'(last_blk[7:0]), BW'(8'h00));
    chk("t1_byte1", BW'(last_blk[15:8]), BW'(8'hFF));
    chk("t1_byte15", BW'(last_blk[127:120]), BW'(8'h86));
    chk("t1_mode", BW'(last_mode), '0);
    chk("t1_accepts", BW'(n_acc), BW'(1));

    // 2: mode tag byte
    send_rand(BB, 8'hFF);
    settle("t2");
    chk("t2_byte0", BW'(last_blk[7:0]), BW'(8'hFF));
`ifdef MODE_TAG_EN
    chk("t2_mode", BW'(last_mode), BW'(1));
`else
    chk("t2_mode", BW'(last_mode), '0);
`endif

    // 3: framing error on the fifth byte aborts the partial block
    send_rand(4, -1);
    send_byte(8'($urandom), 1'b0, 1);
    send_rand(BB, 8'h3C);
    settle("t3");
    chk("t3_fe_count", BW'(n_fe), BW'(1));
    chk("t3_byte0", BW'(last_blk[7:0]), BW'(8'h3C));
    chk("t3_accepts", BW'(n_acc), BW'(3));

    // 4: partial block times out
    send_rand(7, -1);
    if (m_bytes.size() != 0) begin exp_to++; m_bytes.delete(); end
    #(40*BIT_NS);
    send_rand(BB, -1);
    settle("t4");
    chk("t4_to_count", BW'(n_to), BW'(1));
    chk("t4_accepts", BW'(n_acc), BW'(4));

    // 5: overrun while the consumer stalls
    @(posedge clk); #1 block_ready = 1'b0;
    send_rand(BB, -1);
    blk_a = model_blk;
    send_rand(BB, -1);
    #(4*BIT_NS);
    chk("t5_ov_count", BW'(n_ov), BW'(1));
    chk("t5_valid_held", BW'(block_valid), BW'(1));
    chk("t5_data_is_a", block_data, blk_a);
    @(posedge clk); #1 block_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid_drop", BW'(block_valid), '0);
    settle("t5");
    chk("t5_last_is_a", last_blk, blk_a);

    // 6: start glitch, then reset in the middle of a byte
    @(posedge clk); #3 rx = 1'b0;
    #120 chk("t6_glitch_busy", BW'(busy), BW'(1));
    #40 rx = 1'b1;
    #(3*BIT_NS);
    chk("t6_glitch_idle", BW'(busy), '0);
    send_rand(3, -1);
    rx = 1'b0; #(BIT_NS);
    rx = 1'b1; #(BIT_NS*3 + $urandom_range(0, BIT_NS));
    chk("t6_midbyte_busy", BW'(busy), BW'(1));
    @(posedge clk); #1 reset = 1'b1;
    m_bytes.delete();
    #1;
    chk("t6_rst_data", block_data, '0);
    chk("t6_rst_valid", BW'(block_valid), '0);
    chk("t6_rst_busy", BW'(busy), '0);
    chk("t6_rst_pulses", BW'({frame_err, timeout, overrun, block_mode}), '0);
    rx = 1'b1;
    #(2*BIT_NS);
    @(posedge clk); #1 reset = 1'b0;
    #(2*BIT_NS);
    send_rand(BB, -1);
    settle("t6");
    chk("t6_accepts", BW'(n_acc), BW'(6));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
